// File: rtl/idma_stream_id_tracker.sv
// Assigns per-stream transfer IDs to requests forwarded to the iDMA back-end and
// tracks their in-order completion to expose next_id / done_id / busy per stream.
module idma_stream_id_tracker #(
   parameter int unsigned NumStreams     = 1,
   parameter int unsigned IdCounterWidth = 32,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1,
   parameter type         dma_req_t      = logic
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  dma_req_t                                      req_i,
   input  logic                                          req_valid_i,
   output logic                                          req_ready_o,
   input  logic [StreamWidth-1:0]                        stream_idx_i,
   output dma_req_t                                      req_o,
   output logic                                          req_valid_o,
   input  logic                                          req_ready_i,
   input  logic                                          rsp_valid_i,
   output logic [IdCounterWidth-1:0]                     issued_id_o,
   output logic [NumStreams-1:0][IdCounterWidth-1:0]     next_id_o,
   output logic [NumStreams-1:0][IdCounterWidth-1:0]     done_id_o,
   output logic [NumStreams-1:0]                         busy_o,
   output logic [$clog2(MaxOutstanding):0]               outstanding_o,
   output logic                                          err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
   localparam int unsigned PtrW = $clog2(MaxOutstanding);

   // IDs wrap from all-ones back to 1; 0 is reserved for "none completed".
   function automatic logic [IdCounterWidth-1:0] inc_id(input logic [IdCounterWidth-1:0] id);
      if (&id) return IdCounterWidth'(1);
      return id + IdCounterWidth'(1);
   endfunction

   logic [StreamWidth-1:0]                     fifo_q [MaxOutstanding];
   logic [PtrW-1:0]                            wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]                            out_q;
   logic [NumStreams-1:0][IdCounterWidth-1:0]  next_id_q, done_id_q;
   logic [CntW-1:0]                            cnt_q [NumStreams];
   logic [CntW-1:0]                            cnt_d [NumStreams];
   logic [NumStreams-1:0]                      busy_q;
   logic [NumStreams-1:0]                      issue_hit, done_hit;

   logic                   idx_ok, full, empty, fwd, pop;
   logic [StreamWidth-1:0] head;

   assign idx_ok = {1'b0, stream_idx_i} < (StreamWidth + 1)'(NumStreams);
   assign full   = (out_q == CntW'(MaxOutstanding));
   assign empty  = (out_q == '0);
   assign head   = fifo_q[rd_ptr_q];

   // full depends only on registered state, so rsp_valid_i never reaches req_ready_o.
   assign req_valid_o = req_valid_i & idx_ok & ~full;
   assign req_ready_o = idx_ok ? (req_ready_i & ~full) : 1'b1;
   assign fwd         = req_valid_o & req_ready_i;
   assign pop         = rsp_valid_i & ~empty;
   assign err_o       = (req_valid_i & ~idx_ok) | (rsp_valid_i & empty);
   assign req_o       = req_i;

   always_comb begin
      issued_id_o = '0;
      for (int s = 0; s < NumStreams; s++) begin
         issue_hit[s] = fwd && (stream_idx_i == StreamWidth'(s));
         done_hit[s]  = pop && (head == StreamWidth'(s));
         cnt_d[s]     = cnt_q[s] + CntW'(issue_hit[s]) - CntW'(done_hit[s]);
         if (stream_idx_i == StreamWidth'(s)) issued_id_o = next_id_q[s];
      end
   end

   always_ff @(posedge clk_i) begin
      if (fwd) fifo_q[wr_ptr_q] <= stream_idx_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         out_q    <= '0;
         busy_q   <= '0;
         for (int s = 0; s < NumStreams; s++) begin
            next_id_q[s] <= IdCounterWidth'(1);
            done_id_q[s] <= '0;
            cnt_q[s]     <= '0;
         end
      end else begin
         if (fwd) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({fwd, pop})
            2'b10:   out_q <= out_q + CntW'(1);
            2'b01:   out_q <= out_q - CntW'(1);
            default: out_q <= out_q;
         endcase
         for (int s = 0; s < NumStreams; s++) begin
            if (issue_hit[s]) next_id_q[s] <= inc_id(next_id_q[s]);
            if (done_hit[s])  done_id_q[s] <= inc_id(done_id_q[s]);
            cnt_q[s]  <= cnt_d[s];
            busy_q[s] <= (cnt_d[s] != '0);
         end
      end
   end

   assign next_id_o     = next_id_q;
   assign done_id_o     = done_id_q;
   assign busy_o        = busy_q;
   assign outstanding_o = out_q;

endmodule

// File: tb/tb_idma_stream_id_tracker.sv
// Scoreboard bench for idma_stream_id_tracker: 2 streams, 2-bit IDs, 4 outstanding.
module tb_idma_stream_id_tracker;

   localparam int NS = 2;
   localparam int IW = 2;
   localparam int MO = 4;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       req_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [SW-1:0]     stream_idx_i;
   logic [31:0]       req_o;
   logic              req_valid_o;
   logic              req_ready_i;
   logic              rsp_valid_i;
   logic [IW-1:0]     issued_id_o;
   logic [NS-1:0][IW-1:0] next_id_o;
   logic [NS-1:0][IW-1:0] done_id_o;
   logic [NS-1:0]     busy_o;
   logic [$clog2(MO):0] outstanding_o;
   logic              err_o;

   idma_stream_id_tracker #(
      .NumStreams(NS), .IdCounterWidth(IW), .MaxOutstanding(MO),
      .StreamWidth(SW), .dma_req_t(logic [31:0])
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o), .stream_idx_i(stream_idx_i), .req_o(req_o),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .rsp_valid_i(rsp_valid_i),
      .issued_id_o(issued_id_o), .next_id_o(next_id_o), .done_id_o(done_id_o),
      .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int m_next [NS];
   int m_done [NS];
   int m_cnt  [NS];
   int m_out;
   int m_fifo [$];
   int id_q   [$];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int nxt(input int id);
      return (id % 3) + 1;  // 2-bit IDs skipping zero: 0->1, 1->2, 2->3, 3->1
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_next[s] = 1;
         m_done[s] = 0;
         m_cnt[s]  = 0;
      end
      m_out = 0;
      m_fifo.delete();
      id_q.delete();
   endtask

   task automatic check_state(input string tag);
      logic [3:0] en, ed;
      logic [1:0] eb;
      en = {m_next[1][1:0], m_next[0][1:0]};
      ed = {m_done[1][1:0], m_done[0][1:0]};
      eb = {m_cnt[1] != 0, m_cnt[0] != 0};
      check({tag, ".next_id"}, next_id_o, en);
      check({tag, ".done_id"}, done_id_o, ed);
      check({tag, ".busy"}, busy_o, eb);
      check({tag, ".outstanding"}, outstanding_o, m_out);
   endtask

   // Called at a negedge; drives one cycle of stimulus and checks both phases.
   task automatic cycle(input logic v, input logic [SW-1:0] idx, input logic rr, input logic rsp);
      logic ok, full, empty, evo, ero, efwd, eerr, pop;
      logic [31:0] pay;
      int h;
      pay = $urandom;
      req_i = pay; req_valid_i = v; stream_idx_i = idx; req_ready_i = rr; rsp_valid_i = rsp;
      #2;
      ok    = (idx < NS);
      full  = (m_out == MO);
      empty = (m_out == 0);
      evo   = v & ok & ~full;
      ero   = ok ? (rr & ~full) : 1'b1;
      efwd  = evo & rr;
      eerr  = (v & ~ok) | (rsp & empty);
      pop   = rsp & ~empty;
      check("req_valid_o", req_valid_o, evo);
      check("req_ready_o", req_ready_o, ero);
      check("err_o", err_o, eerr);
      check("req_o", req_o, pay);
      if (efwd) id_q.push_back(m_next[idx]);
      if (req_valid_o && req_ready_i) begin
         if (id_q.size() == 0) check("issued_id_unexpected", 1'b1, 1'b0);
         else check("issued_id", issued_id_o, id_q.pop_front());
      end
      if (efwd) begin
         m_fifo.push_back(int'(idx));
         m_cnt[idx]++;
         m_next[idx] = nxt(m_next[idx]);
      end
      if (pop) begin
         h = m_fifo.pop_front();
         m_cnt[h]--;
         m_done[h] = nxt(m_done[h]);
      end
      m_out = m_out + int'(efwd) - int'(pop);
      @(posedge clk);
      #1;
      check_state("post");
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid_i = 1'b0; rsp_valid_i = 1'b0; req_ready_i = 1'b0; stream_idx_i = '0; req_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      check("reset.req_valid_o", req_valid_o, 1'b0);
      check("reset.err_o", err_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic issue on stream 1, then simultaneous push/pop on the same stream
      repeat (3) cycle(1'b1, 2'd1, 1'b1, 1'b0);
      cycle(1'b1, 2'd1, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 2'd0, 1'b1, 1'b1);

      // back-end backpressure: offered but not accepted
      cycle(1'b1, 2'd0, 1'b0, 1'b0);

      // full throttle, completion while full does not admit the request
      repeat (5) cycle(1'b1, 2'd0, 1'b1, 1'b0);
      cycle(1'b1, 2'd0, 1'b1, 1'b1);
      cycle(1'b1, 2'd0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 2'd0, 1'b1, 1'b1);

      // interleaved streams, in-order completions
      cycle(1'b1, 2'd0, 1'b1, 1'b0);
      cycle(1'b1, 2'd1, 1'b1, 1'b0);
      cycle(1'b1, 2'd0, 1'b1, 1'b0);
      cycle(1'b1, 2'd1, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 2'd0, 1'b0, 1'b1);

      // ID wrap on stream 0
      repeat (4) cycle(1'b1, 2'd0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 2'd0, 1'b0, 1'b1);

      // spurious completion and invalid stream, each followed by a quiet cycle
      cycle(1'b0, 2'd0, 1'b0, 1'b1);
      cycle(1'b0, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 2'd3, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, 1'b0, 1'b0);

      // asynchronous reset with transfers in flight
      cycle(1'b1, 2'd0, 1'b1, 1'b0);
      cycle(1'b1, 2'd1, 1'b1, 1'b0);
      cycle(1'b1, 2'd1, 1'b1, 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state("async_rst");
      check("async_rst.req_valid_o", req_valid_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 2'd1, 1'b1, 1'b0);
      cycle(1'b0, 2'd0, 1'b0, 1'b1);

      check("scoreboard_drained", id_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
